// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core's valid/ready data-memory bus.
// Accepts one load/store at a time, waits WAIT_CYCLES, then presents a response
// that is held until the core takes it. Backing store is DEPTH_WORDS x 32 bits.
//
// Ports
//   clk        single clock, all logic on posedge
//   rst        synchronous, active-high reset (memory contents are kept)
//   req_valid  core presents a request
//   req_ready  responder can accept a request this cycle (IDLE only)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_wstrb  byte enables for a store (bit i -> byte i)
//   rsp_valid  response available
//   rsp_ready  core accepts response
//   rsp_rdata  load data (0 for stores and faults)
//   rsp_err    access fault: misaligned or out of range
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request captured at accept; data only, so not reset.
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          commit;
  logic          cur_we;
  logic          cur_err;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wstrb;
  logic [AW-1:0] cur_idx;

  always_comb begin
    accept = (state == IDLE) & req_valid & req_ready;
    // With WAIT_CYCLES == 0 the response is formed on the accept edge itself,
    // before the latches hold anything, so IDLE reads the live request.
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_wstrb = req_wstrb;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_wstrb = wstrb_q;
    end
    cur_idx = cur_addr[2 +: AW];
    // Power-of-two depth: out of range means any word-address bit above the index is set.
    cur_err = (cur_addr[1:0] != 2'b00) | (|cur_addr[31:2+AW]);
    if (WAIT_CYCLES == 0) begin
      enter_resp = accept;
    end else begin
      enter_resp = (state == WAIT) && (cnt == LAST);
    end
    // A store commits only on the edge that enters RESP, so a reset during WAIT drops it.
    commit = enter_resp & cur_we & ~cur_err & ~rst;
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wstrb[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            if (enter_resp) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= cur_err;
              rsp_rdata <= (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (enter_resp) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
            rsp_rdata <= (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and WAIT_CYCLES=0)
// driven by scenario tasks and checked against a word-level memory model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_ready [2];
  wire         req_ready [2];
  wire         rsp_valid [2];
  wire  [31:0] rsp_rdata [2];
  wire         rsp_err   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference memory: key = instance*4096 + word index; only fully known words are stored.
  logic [31:0] mdl [int];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec-level expectation: fault rule, byte-masked merge, load returns stored word.
  task automatic model(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       output logic [31:0] er, output logic ee, output bit known);
    logic [31:0] mask;
    int key;
    ee = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    er = 32'd0;
    known = 1'b1;
    if (ee) return;
    key = sel * 4096 + int'(addr / 4);
    if (we) begin
      mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
      if (mdl.exists(key)) mdl[key] = (mdl[key] & ~mask) | (wdata & mask);
      else if (wstrb == 4'hF) mdl[key] = wdata;
    end else if (mdl.exists(key)) begin
      er = mdl[key];
    end else begin
      known = 1'b0;
    end
  endtask

  // Drives one transaction. During WAIT, rsp_ready toggles randomly (must be ignored);
  // during hold cycles a garbage request is offered (must not be accepted).
  task automatic do_txn(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int acc_cyc, output bit ok, output bit stable);
    int n;
    ok = 1'b1; stable = 1'b1; lat = 0; rdata = 32'd0; err = 1'b0; acc_cyc = 0;
    req_valid[sel] = 1'b1; req_we[sel] = we; req_addr[sel] = addr;
    req_wdata[sel] = wdata; req_wstrb[sel] = wstrb;
    n = 0;
    while (req_ready[sel] !== 1'b1 && n < 20) begin step(); n++; end
    if (n >= 20) begin ok = 1'b0; req_valid[sel] = 1'b0; return; end
    step();
    acc_cyc = cyc;
    req_valid[sel] = 1'b0;
    req_we[sel] = 1'($urandom); req_addr[sel] = $urandom;
    req_wdata[sel] = $urandom; req_wstrb[sel] = 4'($urandom);
    n = 0;
    while (rsp_valid[sel] !== 1'b1 && n < 40) begin
      rsp_ready[sel] = 1'($urandom);
      step();
      n++;
    end
    rsp_ready[sel] = 1'b0;
    if (n >= 40) begin ok = 1'b0; return; end
    lat = n + 1;
    rdata = rsp_rdata[sel];
    err = rsp_err[sel];
    if (hold > 0) req_valid[sel] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      if (rsp_valid[sel] !== 1'b1 || rsp_rdata[sel] !== rdata || rsp_err[sel] !== err ||
          req_ready[sel] !== 1'b0) stable = 1'b0;
    end
    req_valid[sel] = 1'b0;
    rsp_ready[sel] = 1'b1;
    step();
    rsp_ready[sel] = 1'b0;
    if (rsp_valid[sel] !== 1'b0 || req_ready[sel] !== 1'b1) stable = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0; req_wstrb[s] = '0; rsp_ready[s] = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        total++;
        if (req_ready[s] !== 1'b0 || rsp_valid[s] !== 1'b0 || rsp_err[s] !== 1'b0 ||
            rsp_rdata[s] !== 32'd0) begin
          bad++;
          $display("FAIL reset_hold[%0d] c%0d: rdy=%b vld=%b err=%b rdata=%h want 0 0 0 0",
                   s, c, req_ready[s], rsp_valid[s], rsp_err[s], rsp_rdata[s]);
        end
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();
    for (int s = 0; s < 2; s++) begin
      total++;
      if (req_ready[s] !== 1'b1 || rsp_valid[s] !== 1'b0) begin
        bad++;
        $display("FAIL reset_release[%0d]: rdy=%b vld=%b want 1 0", s, req_ready[s], rsp_valid[s]);
      end
    end
  endtask

  task automatic test_basic(input int sel);
    logic [31:0] rd, er; logic e, ee; int lat, ac; bit ok, st, kn;
    do_txn(sel, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e, lat, ac, ok, st);
    model(sel, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er, ee, kn);
    total++;
    if (!ok || e !== 1'b0 || rd !== 32'd0 || lat != wait_of(sel) + 1) begin
      bad++;
      $display("FAIL store_basic[%0d]: ok=%0d err=%b rdata=%h lat=%0d want 1 0 0 %0d",
               sel, ok, e, rd, lat, wait_of(sel) + 1);
    end
    do_txn(sel, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat, ac, ok, st);
    total++;
    if (!ok || e !== 1'b0 || rd !== 32'hDEADBEEF || lat != wait_of(sel) + 1) begin
      bad++;
      $display("FAIL load_basic[%0d]: ok=%0d err=%b rdata=%h lat=%0d want 1 0 deadbeef %0d",
               sel, ok, e, rd, lat, wait_of(sel) + 1);
    end
  endtask

  task automatic test_partial(input int sel);
    logic [31:0] rd, er; logic e, ee; int lat, ac; bit ok, st, kn;
    do_txn(sel, 1'b1, 32'h10, 32'h00001234, 4'b0011, 0, rd, e, lat, ac, ok, st);
    model(sel, 1'b1, 32'h10, 32'h00001234, 4'b0011, er, ee, kn);
    do_txn(sel, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, e, lat, ac, ok, st);
    model(sel, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, er, ee, kn);
    do_txn(sel, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat, ac, ok, st);
    total++;
    if (!ok || e !== 1'b0 || rd !== 32'hDEAD1234) begin
      bad++;
      $display("FAIL partial_store[%0d]: ok=%0d err=%b rdata=%h want 1 0 dead1234", sel, ok, e, rd);
    end
  endtask

  task automatic test_faults(input int sel);
    logic [31:0] rd, er; logic e, ee; int lat, ac; bit ok, st, kn;
    do_txn(sel, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, e, lat, ac, ok, st);
    model(sel, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, er, ee, kn);
    do_txn(sel, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, e, lat, ac, ok, st);
    total++;
    if (!ok || e !== 1'b1 || rd !== 32'd0) begin
      bad++;
      $display("FAIL misaligned_load[%0d]: ok=%0d err=%b rdata=%h want 1 1 0", sel, ok, e, rd);
    end
    do_txn(sel, 1'b1, 32'h1000, 32'h11111111, 4'hF, 0, rd, e, lat, ac, ok, st);
    total++;
    if (!ok || e !== 1'b1 || rd !== 32'd0) begin
      bad++;
      $display("FAIL range_store[%0d]: ok=%0d err=%b rdata=%h want 1 1 0", sel, ok, e, rd);
    end
    do_txn(sel, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, e, lat, ac, ok, st);
    total++;
    if (!ok || e !== 1'b0 || rd !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL word0_intact[%0d]: ok=%0d err=%b rdata=%h want 1 0 0badf00d", sel, ok, e, rd);
    end
  endtask

  task automatic test_backpressure(input int sel);
    logic [31:0] rd; logic e; int lat, ac; bit ok, st;
    do_txn(sel, 1'b0, 32'h10, 32'h0, 4'h0, 4, rd, e, lat, ac, ok, st);
    total++;
    if (!ok || !st || e !== 1'b0 || rd !== 32'hDEAD1234) begin
      bad++;
      $display("FAIL backpressure[%0d]: ok=%0d stable=%0d err=%b rdata=%h want 1 1 0 dead1234",
               sel, ok, st, e, rd);
    end
  endtask

  task automatic test_back_to_back(input int sel);
    logic [31:0] rd, er; logic e, ee; int lat, a0, a1; bit ok0, ok1, st, kn;
    do_txn(sel, 1'b1, 32'h14, 32'hCAFE0001, 4'hF, 0, rd, e, lat, a0, ok0, st);
    model(sel, 1'b1, 32'h14, 32'hCAFE0001, 4'hF, er, ee, kn);
    do_txn(sel, 1'b0, 32'h14, 32'h0, 4'h0, 0, rd, e, lat, a1, ok1, st);
    total++;
    if (!ok0 || !ok1 || a1 - a0 != wait_of(sel) + 2 || rd !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL back_to_back[%0d]: ok=%0d%0d spacing=%0d rdata=%h want spacing %0d cafe0001",
               sel, ok0, ok1, a1 - a0, rd, wait_of(sel) + 2);
    end
  endtask

  task automatic test_midreset(input int sel);
    logic [31:0] rd, er; logic e, ee; int lat, ac, n; bit ok, st, kn;
    do_txn(sel, 1'b1, 32'h20, 32'h55AA55AA, 4'hF, 0, rd, e, lat, ac, ok, st);
    model(sel, 1'b1, 32'h20, 32'h55AA55AA, 4'hF, er, ee, kn);
    // Reset in WAIT (store not yet committed) or, with no WAIT state, in RESP of a load.
    req_valid[sel] = 1'b1; req_we[sel] = (sel == 0); req_addr[sel] = 32'h20;
    req_wdata[sel] = 32'h12345678; req_wstrb[sel] = 4'hF;
    n = 0;
    while (req_ready[sel] !== 1'b1 && n < 20) begin step(); n++; end
    step();
    req_valid[sel] = 1'b0;
    rst[sel] = 1'b1;
    step();
    total++;
    if (rsp_valid[sel] !== 1'b0 || req_ready[sel] !== 1'b0 || rsp_err[sel] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_assert[%0d]: vld=%b rdy=%b err=%b want 0 0 0",
               sel, rsp_valid[sel], req_ready[sel], rsp_err[sel]);
    end
    rst[sel] = 1'b0;
    step();
    total++;
    if (rsp_valid[sel] !== 1'b0 || req_ready[sel] !== 1'b1) begin
      bad++;
      $display("FAIL midreset_release[%0d]: vld=%b rdy=%b want 0 1", sel, rsp_valid[sel], req_ready[sel]);
    end
    do_txn(sel, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat, ac, ok, st);
    total++;
    if (!ok || e !== 1'b0 || rd !== 32'h55AA55AA) begin
      bad++;
      $display("FAIL midreset_old_data[%0d]: ok=%0d err=%b rdata=%h want 1 0 55aa55aa", sel, ok, e, rd);
    end
  endtask

  task automatic test_random(input int sel);
    logic [31:0] rd, er, addr, wd; logic e, ee, we; logic [3:0] ws;
    int lat, ac, hold, kind; bit ok, st, kn;
    for (int k = 0; k < 56; k++) begin
      if (k < 16) begin
        we = 1'b1; addr = 32'(k * 4); wd = $urandom; ws = 4'hF; hold = 0;
      end else begin
        kind = $urandom_range(0, 19);
        we = 1'($urandom); wd = $urandom; ws = 4'($urandom); hold = $urandom_range(0, 3);
        addr = 32'($urandom_range(0, 15) * 4);
        if (kind < 3) addr = addr + 32'($urandom_range(1, 3));
        else if (kind < 6) addr = ($urandom & 32'hFFFF_FFFC) | 32'h1000;
      end
      do_txn(sel, we, addr, wd, ws, hold, rd, e, lat, ac, ok, st);
      model(sel, we, addr, wd, ws, er, ee, kn);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rand_timeout[%0d] #%0d: handshake did not complete", sel, k);
      end else begin
        if (e !== ee || (kn && rd !== er)) begin
          bad++;
          $display("FAIL rand_data[%0d] #%0d we=%b a=%h: err=%b rdata=%h want err=%b rdata=%h",
                   sel, k, we, addr, e, rd, ee, er);
        end
        total++;
        if (lat != wait_of(sel) + 1 || !st) begin
          bad++;
          $display("FAIL rand_timing[%0d] #%0d: lat=%0d stable=%0d want %0d 1",
                   sel, k, lat, st, wait_of(sel) + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    for (int s = 0; s < 2; s++) begin
      test_basic(s);
      test_partial(s);
      test_faults(s);
      test_backpressure(s);
      test_back_to_back(s);
      test_midreset(s);
      test_random(s);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
